// File: rtl/uart_reg_interface_if.sv
// Register-bus interface between the host control FSM and the UART block.
//   wr_i       : write strobe, one access per cycle
//   reg_sel_i  : 0 = control register, 1 = data registers
//   addr_i     : data register select (0 = TX data, 1 = RX data)
//   entrada_i  : write data
//   salida_o   : combinational read data for the current selection
// master = host side, slave = UART side.
`timescale 1ns/1ps
interface uart_reg_interface_if;
  logic        wr_i;
  logic        reg_sel_i;
  logic        addr_i;
  logic [31:0] entrada_i;
  logic [31:0] salida_o;

  modport master (
    output wr_i, reg_sel_i, addr_i, entrada_i,
    input  salida_o
  );

  modport slave (
    input  wr_i, reg_sel_i, addr_i, entrada_i,
    output salida_o
  );
endinterface

// File: rtl/uart_reg_interface.sv
// Memory-mapped 8N1 UART (LSB first) with a control register and TX/RX
// data registers.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : register access port (uart_reg_interface_if.slave)
//   rx   : asynchronous serial input
//   tx   : serial output, idles high
// Control register: bit0 send/busy, bit1 new_rx, bit2 frame_err,
// bit3 overrun; bits 31:4 read 0. Status bits 1..3 are set by hardware
// and cleared by writing 0 to them; a hardware set beats a same-cycle
// software clear.
`timescale 1ns/1ps
module uart_reg_interface #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_reg_interface_if.slave  bus,
  input  logic                 rx,
  output logic                 tx
);
  // clock cycles per bit; must be at least 4
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // register file
  logic        send;
  logic        new_rx;
  logic        frame_err;
  logic        overrun;
  logic [31:0] tx_data;
  logic [7:0]  rx_data;

  // TX datapath
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_q;

  // RX datapath
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;

  // bus decode
  logic       ctrl_wr;
  logic       txd_wr;
  logic       tx_start;
  logic       tx_done;
  logic       rx_stop_smp;
  logic       rx_ok;
  logic       rx_ferr;
  logic [3:1] keep;

  always_comb begin
    ctrl_wr     = bus.wr_i & ~bus.reg_sel_i;
    txd_wr      = bus.wr_i &  bus.reg_sel_i & ~bus.addr_i;
    tx_start    = ctrl_wr & bus.entrada_i[0] & ~send;
    tx_done     = (tx_state == S_STOP) && (tx_cnt == CNT_BIT);
    rx_stop_smp = (rx_state == S_STOP) && (rx_cnt == CNT_BIT);
    rx_ok       = rx_stop_smp &  rx_s;
    rx_ferr     = rx_stop_smp & ~rx_s;
    // a written 0 clears a status bit, a written 1 leaves it alone
    keep        = ctrl_wr ? bus.entrada_i[3:1] : 3'b111;
  end

  // ---------------------------------------------------------------------
  // control / data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      send      <= 1'b0;
      new_rx    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      tx_data   <= '0;
      rx_data   <= '0;
    end else begin
      // start only from idle; a running frame cannot be aborted
      if (tx_start)     send <= 1'b1;
      else if (tx_done) send <= 1'b0;

      // overrun looks at new_rx before this edge's clear takes effect
      new_rx    <= (new_rx    & keep[1]) | rx_ok;
      frame_err <= (frame_err & keep[2]) | rx_ferr;
      overrun   <= (overrun   & keep[3]) | (rx_ok & new_rx);

      // the TX byte is frozen while a frame is in flight
      if (txd_wr && !send) tx_data <= bus.entrada_i;
      if (rx_ok)           rx_data <= rx_shreg;
    end
  end

  // ---------------------------------------------------------------------
  // TX: registered line so tx drops one cycle after the send write
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_start) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
            tx_shreg <= tx_data[7:0];
            tx_q     <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == CNT_BIT) begin
            tx_state <= S_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_q     <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == CNT_BIT) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx_q     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_q     <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin // S_STOP
          if (tx_cnt == CNT_BIT) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------------
  // RX: 2-flop synchronizer, then start-edge detect and mid-bit sampling
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          // half a bit in: still low means a real start bit, else a glitch
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == CNT_BIT) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin // S_STOP: flags handled in the register block
          if (rx_cnt == CNT_BIT) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // read mux
  // ---------------------------------------------------------------------
  always_comb begin
    bus.salida_o = {28'd0, overrun, frame_err, new_rx, send};
    if (bus.reg_sel_i) begin
      if (bus.addr_i) bus.salida_o = {24'd0, rx_data};
      else            bus.salida_o = tx_data;
    end
  end

endmodule

// File: doc/uart_reg_interface.md
Name: uart_reg_interface

Overview:
- Memory-mapped UART peripheral that answers the host-side control FSM's register accesses (wr_i / reg_sel_i / addr_i / entrada_i, read back on salida_o).
- Holds a control register and TX/RX data registers.
- Serializes the TX byte on the tx line when the send bit is set.
- Deserializes bytes arriving on the rx line, then raises new_rx.
- Format is 8N1, LSB first.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- DIV, CLK_FREQ/BAUD (derived localparam), clock cycles per bit; must be ≥ 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_i  in  1  write enable, one access per cycle
- reg_sel_i  in  1  0 = control register, 1 = data registers
- addr_i  in  1  data register select: 0 = TX data, 1 = RX data (ignored when reg_sel_i = 0)
- entrada_i  in  32  write data
- salida_o  out  32  read data for the currently selected register (combinational)
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output

Behaviour:
- Clocking and reset:
  - One clock, single clk domain. Reset is synchronous and active-high: rst is sampled on posedge clk.
  - Reset values: ctrl = 0, tx_data = 0, rx_data = 0, tx = 1, both FSMs IDLE, all counters 0.
- Control register bits (bits 31:4 read 0):
  - bit 0 send = TX busy.
  - bit 1 new_rx.
  - bit 2 frame_err.
  - bit 3 overrun.
- Read path:
  - salida_o = ctrl when reg_sel_i = 0.
  - salida_o = tx_data when reg_sel_i = 1 and addr_i = 0.
  - salida_o = {24'b0, rx_data} when reg_sel_i = 1 and addr_i = 1.
  - Zero latency; reflects register values after the last clock edge.
- Writes, applied at the clock edge where wr_i = 1:
  - TX data write: tx_data <= entrada_i (all 32 bits stored; only bits 7:0 are transmitted). Ignored while send = 1.
  - RX data write: ignored.
  - Control write, send: entrada_i[0] = 1 with send = 0 sets send and starts TX. Writing 0, or any write while busy, leaves send unchanged; a transmission cannot be aborted.
  - Control write, bits 1..3: entrada_i[k] = 0 clears bit k; 1 leaves it unchanged (hardware set only).
  - Same-cycle software clear and hardware set of any status bit: set wins.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: tx = 1. On the edge that sets send, latch shreg <= tx_data[7:0], go to START.
  - START: tx = 0 for DIV cycles.
  - DATA: shifts out 8 bits LSB first, DIV cycles each.
  - STOP: tx = 1 for DIV cycles, then send <= 0 and return to IDLE.
  - Timing: tx falls the cycle after the write edge; a frame is exactly 10·DIV cycles from tx falling to send clearing.
  - Back-to-back: a new send write is accepted the cycle after send clears.
- RX FSM (IDLE, START, DATA, STOP):
  - rx passes through a 2-flop synchronizer (rx_s); reset value 1.
  - IDLE: a falling edge of rx_s goes to START.
  - START: after DIV/2 cycles, re-sample. rx_s = 1 is a glitch: return to IDLE with no flags. rx_s = 0: go to DATA.
  - DATA: sample 8 bits at DIV-cycle intervals (mid-bit), LSB first.
  - STOP: sample after DIV cycles.
    - rx_s = 1: rx_data <= byte and new_rx <= 1. If new_rx was already 1, also set overrun (the new byte overwrites).
    - rx_s = 0: set frame_err, rx_data unchanged, new_rx unchanged.
  - Return to IDLE immediately after the stop sample. A start edge is accepted from the next cycle.
- Concurrency and reset:
  - TX and RX are fully independent; full duplex allowed.
  - rst mid-frame: tx returns to 1 the next cycle and the frame is abandoned, with no flags.

Test Plan:
- Bench runs with CLK_FREQ = 16, BAUD = 1 (DIV = 16).
- Reset: assert rst 2 cycles -> tx = 1, salida_o = 0 for all three selections, ctrl = 0.
- TX: write tx_data = 32'h0000_00A5, then ctrl = 1.
  - tx falls 1 cycle later.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles.
  - send reads 1 throughout and clears exactly 160 cycles after tx falls.
  - tx_data write during the frame does not change the transmitted bits.
- RX: drive frame for 8'h3C at 16 cycles/bit.
  - new_rx = 1 within 3 cycles after the mid-stop sample.
  - rx_data reads 32'h0000_003C.
  - Writing ctrl = 0 clears new_rx.
  - Write rx_data = 32'hFFFF_FFFF -> rx_data still reads 32'h0000_003C.
- Errors:
  - rx low pulse of 4 cycles -> no flags.
  - Frame with stop bit = 0 -> frame_err = 1, new_rx = 0.
  - Two good frames 8'h11 then 8'h22 without clearing -> overrun = 1, rx_data = 8'h22.
- Simultaneous events: write ctrl = 0 on the same edge the RX stop sample sets new_rx -> new_rx = 1.
  - Full duplex: TX 8'hF0 while receiving 8'h0F -> both complete correctly.
- Reset mid-frame: assert rst at bit 4 of a TX frame -> tx = 1 the next cycle, send = 0, and a new send starts a clean frame.
